// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM arbiter: requester ids, default widths and mask helper.
package ram_arb_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  localparam int unsigned RAM_ARB_ADDR_W = 8;
  localparam int unsigned RAM_ARB_DATA_W = 8;

  // One-hot request mask ({B, A}) that admits only the given requester.
  function automatic logic [1:0] req_onehot(req_id_e id);
    return (id == REQ_A) ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a tie goes to the requester that was not granted last.
// Requests outside i_allow are masked; no grant is issued while i_rst is high.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic [1:0] i_allow,
  output logic [1:0] o_gnt
);

  req_id_e    last_q, last_d;
  logic [1:0] req_eff;

  always_comb begin
    req_eff = i_rst ? 2'b00 : (i_req & i_allow);
    o_gnt   = 2'b00;
    unique case (req_eff)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (last_q == REQ_A) ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase

    last_d = last_q;
    if (o_gnt[0]) begin
      last_d = REQ_A;
    end else if (o_gnt[1]) begin
      last_d = REQ_B;
    end
  end

  // Pointer starts at B so that A wins the first tie.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_q <= REQ_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with registered per-owner read data.
// Define RAM_ARB_LOCK_EN to enable the owner bus lock for atomic multi-access sequences.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ARB_ADDR_W,
  parameter int unsigned DATA_W = RAM_ARB_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,

  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  input  logic              i_a_lock,
  output logic              o_a_gnt,
  output logic              o_a_rvalid,
  output logic [DATA_W-1:0] o_a_rdata,

  input  logic              i_b_req,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  input  logic              i_b_lock,
  output logic              o_b_gnt,
  output logic              o_b_rvalid,
  output logic [DATA_W-1:0] o_b_rdata,

  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_data,
  output logic              o_ram_we,
  input  logic [DATA_W-1:0] i_ram_data
);

  logic [1:0] req;
  logic [1:0] allow;
  logic [1:0] gnt;
  logic       gnt_any;
  req_id_e    gnt_id;

  req_id_e    sel_q, sel_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  assign req = {i_b_req, i_a_req};

  rr_arb2 u_rr_arb2 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (req),
    .i_allow (allow),
    .o_gnt   (gnt)
  );

  always_comb begin
    gnt_any = |gnt;
    gnt_id  = gnt[1] ? REQ_B : REQ_A;
  end

`ifdef RAM_ARB_LOCK_EN
  logic    lock_q, lock_d;
  req_id_e owner_q, owner_d;

  // Every grant while locked belongs to the owner, so the granted lock bit alone
  // decides whether the lock persists. Round-robin pointer already points at the owner.
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    if (gnt_any) begin
      lock_d  = gnt[1] ? i_b_lock : i_a_lock;
      owner_d = gnt_id;
    end
    allow = lock_q ? req_onehot(owner_q) : 2'b11;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_q  <= 1'b0;
      owner_q <= REQ_A;
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = i_a_lock ^ i_b_lock;
  assign allow       = 2'b11;
`endif

  always_comb begin
    sel_d      = gnt_any ? gnt_id : sel_q;
    a_rvalid_d = gnt[0] & ~i_a_we;
    b_rvalid_d = gnt[1] & ~i_b_we;
    a_rdata_d  = a_rvalid_d ? i_ram_data : a_rdata_q;
    b_rdata_d  = b_rvalid_d ? i_ram_data : b_rdata_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sel_q      <= REQ_A;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      sel_q      <= sel_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  // Idle cycles keep steering the RAM from the last granted requester.
  always_comb begin
    o_ram_addr = (sel_d == REQ_B) ? i_b_addr  : i_a_addr;
    o_ram_data = (sel_d == REQ_B) ? i_b_wdata : i_a_wdata;
    o_ram_we   = (gnt[0] & i_a_we) | (gnt[1] & i_b_we);
  end

  assign o_a_gnt    = gnt[0];
  assign o_b_gnt    = gnt[1];
  assign o_a_rvalid = a_rvalid_q;
  assign o_b_rvalid = b_rvalid_q;
  assign o_a_rdata  = a_rdata_q;
  assign o_b_rdata  = b_rdata_q;

  a_gnt_exclusive: assert property (@(posedge i_clk) !(o_a_gnt && o_b_gnt));
  a_we_needs_gnt:  assert property (@(posedge i_clk) o_ram_we |-> (o_a_gnt || o_b_gnt));
  a_rst_quiet:     assert property (@(posedge i_clk) i_rst |-> !(o_ram_we || o_a_gnt || o_b_gnt));

endmodule
